// File: rtl/gomoku_board_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : gomoku_board_arbiter_if
// Brief    : Client/RAM signal bundle for the gomoku board arbiter.
// Revision : 1.0
// ============================================================================
interface gomoku_board_arbiter_if;
    logic       clear_req;
    logic       memrst_done;
    logic       wr_req;
    logic [5:0] wr_addr;
    logic [1:0] wr_data;
    logic       wr_ack;
    logic       wr_reject;
    logic       chk_req;
    logic [5:0] chk_addr;
    logic       chk_ack;
    logic       chk_valid;
    logic [1:0] chk_rdata;
    logic       scan_req;
    logic [5:0] scan_addr;
    logic       scan_ack;
    logic       scan_valid;
    logic [1:0] scan_rdata;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [1:0] ram_wdata;
    logic [1:0] ram_rdata;

    modport slave (
        input  clear_req, wr_req, wr_addr, wr_data, chk_req, chk_addr,
               scan_req, scan_addr, ram_rdata,
        output memrst_done, wr_ack, wr_reject, chk_ack, chk_valid, chk_rdata,
               scan_ack, scan_valid, scan_rdata, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output clear_req, wr_req, wr_addr, wr_data, chk_req, chk_addr,
               scan_req, scan_addr, ram_rdata,
        input  memrst_done, wr_ack, wr_reject, chk_ack, chk_valid, chk_rdata,
               scan_ack, scan_valid, scan_rdata, ram_addr, ram_we, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/gomoku_board_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gomoku_board_arbiter
// Brief    : Single-port 8x8 board RAM arbiter: clear sweep, writer priority,
//            round-robin checker/scanner reads. GOMOKU_OCCUPY_CHECK_EN adds a
//            read-before-write occupancy check (state WCHK).
// Revision : 1.0
// ============================================================================
module gomoku_board_arbiter (
    input  wire clk,
    input  wire rst_n,
    gomoku_board_arbiter_if.slave bus
);

`ifdef GOMOKU_OCCUPY_CHECK_EN
    typedef enum logic [1:0] {ST_SWEEP = 2'd0, ST_SERVE = 2'd1, ST_WCHK = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_SWEEP = 2'd0, ST_SERVE = 2'd1} state_t;
`endif

    localparam logic [5:0] C_LAST_CELL = 6'd63;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_nxt;
    logic       r_live;
    logic       r_done;
    logic       w_done_nxt;
    logic       r_prefer_scan;
    logic       w_prefer_scan_nxt;
    logic       r_chk_valid;
    logic       r_scan_valid;
    logic       w_wr_ack;
    logic       w_wr_reject;
    logic       w_chk_ack;
    logic       w_scan_ack;
    logic [5:0] w_ram_addr;
    logic       w_ram_we;
    logic [1:0] w_ram_wdata;

    // r_live holds off the sweep for the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_SWEEP;
            r_cnt         <= 6'd0;
            r_live        <= 1'b0;
            r_done        <= 1'b0;
            r_prefer_scan <= 1'b0;
            r_chk_valid   <= 1'b0;
            r_scan_valid  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_live        <= 1'b1;
            r_done        <= w_done_nxt;
            r_prefer_scan <= w_prefer_scan_nxt;
            r_chk_valid   <= w_chk_ack;
            r_scan_valid  <= w_scan_ack;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_done_nxt        = r_done;
        w_prefer_scan_nxt = r_prefer_scan;
        w_wr_ack          = 1'b0;
        w_wr_reject       = 1'b0;
        w_chk_ack         = 1'b0;
        w_scan_ack        = 1'b0;
        w_ram_addr        = 6'd0;
        w_ram_we          = 1'b0;
        w_ram_wdata       = 2'b00;

        case (r_state)
            ST_SWEEP: begin
                w_ram_addr = r_cnt;
                w_ram_we   = r_live;
                if (r_live) begin
                    w_cnt_nxt = r_cnt + 6'd1;
                    if (r_cnt == C_LAST_CELL) begin
                        w_state_nxt = ST_SERVE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_SERVE: begin
                if (bus.wr_req) begin
`ifdef GOMOKU_OCCUPY_CHECK_EN
                    w_ram_addr  = bus.wr_addr;
                    w_state_nxt = ST_WCHK;
`else
                    w_ram_addr  = bus.wr_addr;
                    w_ram_we    = 1'b1;
                    w_ram_wdata = bus.wr_data;
                    w_wr_ack    = 1'b1;
`endif
                end else if (bus.chk_req && (!bus.scan_req || !r_prefer_scan)) begin
                    w_chk_ack         = 1'b1;
                    w_ram_addr        = bus.chk_addr;
                    w_prefer_scan_nxt = 1'b1;
                end else if (bus.scan_req) begin
                    w_scan_ack        = 1'b1;
                    w_ram_addr        = bus.scan_addr;
                    w_prefer_scan_nxt = 1'b0;
                end
            end
`ifdef GOMOKU_OCCUPY_CHECK_EN
            // Writer keeps the RAM: the occupancy read from last cycle is on ram_rdata now.
            ST_WCHK: begin
                w_ram_addr  = bus.wr_addr;
                w_state_nxt = ST_SERVE;
                if (!bus.clear_req) begin
                    if (bus.ram_rdata == 2'b00) begin
                        w_ram_we    = 1'b1;
                        w_ram_wdata = bus.wr_data;
                        w_wr_ack    = 1'b1;
                    end else begin
                        w_wr_reject = 1'b1;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = ST_SWEEP;
            end
        endcase

        if (bus.clear_req) begin
            w_state_nxt = ST_SWEEP;
            w_cnt_nxt   = 6'd0;
            w_done_nxt  = 1'b0;
        end
    end

    assign bus.memrst_done = r_done;
    assign bus.wr_ack      = w_wr_ack;
    assign bus.wr_reject   = w_wr_reject;
    assign bus.chk_ack     = w_chk_ack;
    assign bus.scan_ack    = w_scan_ack;
    assign bus.chk_valid   = r_chk_valid;
    assign bus.scan_valid  = r_scan_valid;
    assign bus.chk_rdata   = r_chk_valid  ? bus.ram_rdata : 2'b00;
    assign bus.scan_rdata  = r_scan_valid ? bus.ram_rdata : 2'b00;
    assign bus.ram_addr    = w_ram_addr;
    assign bus.ram_we      = w_ram_we;
    assign bus.ram_wdata   = w_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_gomoku_board_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gomoku_board_arbiter
// Brief    : Directed + randomized self-checking bench with board RAM model.
// Revision : 1.0
// ============================================================================
module tb_gomoku_board_arbiter;

`ifdef GOMOKU_OCCUPY_CHECK_EN
    localparam bit OCC    = 1'b1;
    localparam int WR_LAT = 2;
`else
    localparam bit OCC    = 1'b0;
    localparam int WR_LAT = 1;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       prefill = 1'b1;
    int         total   = 0;
    int         bad     = 0;
    logic [1:0] mem   [64];
    logic [1:0] board [64];

    always #5 clk = ~clk;

    gomoku_board_arbiter_if bus ();

    gomoku_board_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External single-port RAM: registered read of the pre-write contents.
    always @(posedge clk) begin
        if (prefill) begin
            for (int i = 0; i < 64; i++) mem[i] <= 2'($urandom_range(1, 3));
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_nonzero();
        int c = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 2'b00) c++;
        return c;
    endfunction

    // Called at posedge+1; n counts edges until memrst_done is seen high.
    task automatic wait_done(input int first_n, input int exp_n, input string tag);
        int   n    = 0;
        logic seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (n == first_n) begin
                check({tag, "_first_addr"}, 32'(bus.ram_addr), 0);
                check({tag, "_first_we"}, 32'(bus.ram_we), 1);
            end
            if (bus.memrst_done === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        check({tag, "_cycles"}, n, exp_n);
        @(posedge clk);
        #1;
        check({tag, "_cells_zero"}, count_nonzero(), 0);
        for (int i = 0; i < 64; i++) board[i] = 2'b00;
    endtask

    task automatic wr(input logic [5:0] a, input logic [1:0] d, input string tag);
        int   n   = 0;
        logic ack = 1'b0;
        logic rej = 1'b0;
        logic acc;
        acc         = !OCC || (board[a] == 2'b00);
        bus.wr_req  = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        while (!ack && !rej && n < 20) begin
            @(negedge clk);
            n++;
            ack = bus.wr_ack;
            rej = bus.wr_reject;
            @(posedge clk);
            #1;
        end
        bus.wr_req = 1'b0;
        check({tag, "_ack"}, 32'(ack), 32'(acc));
        check({tag, "_reject"}, 32'(rej), 32'(!acc));
        check({tag, "_lat"}, n, WR_LAT);
        if (acc) board[a] = d;
    endtask

    task automatic rd(input logic sc, input logic [5:0] a, input string tag);
        int   n   = 0;
        logic got = 1'b0;
        if (sc) begin bus.scan_req = 1'b1; bus.scan_addr = a; end
        else    begin bus.chk_req  = 1'b1; bus.chk_addr  = a; end
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = sc ? bus.scan_ack : bus.chk_ack;
            @(posedge clk);
            #1;
        end
        bus.scan_req = 1'b0;
        bus.chk_req  = 1'b0;
        check({tag, "_ack"}, 32'(got), 1);
        @(negedge clk);
        check({tag, "_valid"}, 32'(sc ? bus.scan_valid : bus.chk_valid), 1);
        check({tag, "_rdata"}, 32'(sc ? bus.scan_rdata : bus.chk_rdata), 32'(board[a]));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] ca;
        logic [5:0] sa;
        logic [1:0] pd;
        logic       pchk;
        int         wa;
        int         cka;
        int         n;
        logic       pend;

        bus.clear_req = 1'b0;
        bus.wr_req    = 1'b1;
        bus.wr_addr   = 6'd1;
        bus.wr_data   = 2'b01;
        bus.chk_req   = 1'b1;
        bus.chk_addr  = 6'd5;
        bus.scan_req  = 1'b1;
        bus.scan_addr = 6'd9;
        pchk          = 1'b0;
        pd            = 2'b00;

        // Reset values with every client requesting
        repeat (3) @(posedge clk);
        #1;
        prefill = 1'b0;
        @(negedge clk);
        check("rst_done", 32'(bus.memrst_done), 0);
        check("rst_we", 32'(bus.ram_we), 0);
        check("rst_addr", 32'(bus.ram_addr), 0);
        check("rst_wdata", 32'(bus.ram_wdata), 0);
        check("rst_wr_ack", 32'(bus.wr_ack), 0);
        check("rst_wr_reject", 32'(bus.wr_reject), 0);
        check("rst_chk_ack", 32'(bus.chk_ack), 0);
        check("rst_scan_ack", 32'(bus.scan_ack), 0);
        check("rst_chk_valid", 32'(bus.chk_valid), 0);
        check("rst_scan_valid", 32'(bus.scan_valid), 0);
        check("rst_chk_rdata", 32'(bus.chk_rdata), 0);
        check("rst_scan_rdata", 32'(bus.scan_rdata), 0);
        bus.wr_req   = 1'b0;
        bus.chk_req  = 1'b0;
        bus.scan_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_done(1, 65, "por");

        // Idle service cycle
        @(negedge clk);
        check("idle_we", 32'(bus.ram_we), 0);
        check("idle_acks", 32'({bus.wr_ack, bus.chk_ack, bus.scan_ack}), 0);
        @(posedge clk);
        #1;

        // Random moves, keeping 0x3A untouched for the later directed case
        for (int i = 0; i < 16; i++) begin
            ca = 6'($urandom);
            if (ca == 6'h3A) ca = 6'h3B;
            wr(ca, 2'($urandom_range(1, 2)), "rnd_wr");
        end

        // Both readers held: grants alternate starting with chk
        ca = 6'($urandom);
        sa = 6'($urandom);
        bus.chk_addr  = ca;
        bus.scan_addr = sa;
        bus.chk_req   = 1'b1;
        bus.scan_req  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("rr_chk_valid", 32'(bus.chk_valid), 32'(pchk));
                check("rr_scan_valid", 32'(bus.scan_valid), 32'(!pchk));
                check("rr_rdata", 32'(pchk ? bus.chk_rdata : bus.scan_rdata), 32'(pd));
            end
            check("rr_chk_ack", 32'(bus.chk_ack), 32'(k % 2 == 0));
            check("rr_scan_ack", 32'(bus.scan_ack), 32'(k % 2 == 1));
            pchk = (k % 2 == 0);
            pd   = pchk ? board[ca] : board[sa];
            @(posedge clk);
            #1;
            if (pchk) begin ca = 6'($urandom); bus.chk_addr  = ca; end
            else      begin sa = 6'($urandom); bus.scan_addr = sa; end
        end
        bus.chk_req  = 1'b0;
        bus.scan_req = 1'b0;
        @(negedge clk);
        check("rr_last_valid", 32'(bus.scan_valid), 1);
        check("rr_last_rdata", 32'(bus.scan_rdata), 32'(pd));
        @(posedge clk);
        #1;

        // Clear, then restart the sweep again when the counter reaches 30
        bus.clear_req = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_req = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("sw30_addr", 32'(bus.ram_addr), 30);
        check("sw30_we", 32'(bus.ram_we), 1);
        check("sw30_done", 32'(bus.memrst_done), 0);
        bus.clear_req = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_req = 1'b0;
        wait_done(0, 64, "restart");

        // Writer beats a simultaneous checker; checker then sees the new cell
        bus.wr_req   = 1'b1;
        bus.wr_addr  = 6'h3A;
        bus.wr_data  = 2'b01;
        bus.chk_req  = 1'b1;
        bus.chk_addr = 6'h3A;
        wa   = 0;
        cka  = 0;
        n    = 0;
        pend = 1'b0;
        while (!(wa != 0 && cka != 0 && !pend) && n < 20) begin
            @(negedge clk);
            n++;
            if (pend) begin
                check("prio_chk_valid", 32'(bus.chk_valid), 1);
                check("prio_chk_rdata", 32'(bus.chk_rdata), 32'(2'b01));
                pend = 1'b0;
            end
            if (bus.wr_ack === 1'b1 && wa == 0) wa = n;
            if (bus.chk_ack === 1'b1 && cka == 0) begin cka = n; pend = 1'b1; end
            @(posedge clk);
            #1;
            if (wa != 0)  bus.wr_req  = 1'b0;
            if (cka != 0) bus.chk_req = 1'b0;
        end
        bus.wr_req  = 1'b0;
        bus.chk_req = 1'b0;
        check("prio_wr_lat", wa, WR_LAT);
        check("prio_chk_after_wr", 32'(cka > wa), 1);
        board[6'h3A] = 2'b01;

        // Second move onto the same cell
        wr(6'h3A, 2'b10, "occ_wr");
        rd(1'b0, 6'h3A, "occ_chk");
        check("occ_cell", 32'(mem[6'h3A]), OCC ? 32'(2'b01) : 32'(2'b10));

        // Random mix of moves and reads
        for (int i = 0; i < 40; i++) begin
            ca = 6'($urandom);
            case ($urandom_range(0, 2))
                0:       wr(ca, 2'($urandom_range(1, 2)), "mix_wr");
                1:       rd(1'b0, ca, "mix_chk");
                default: rd(1'b1, ca, "mix_scan");
            endcase
        end

        // Clear from service drops done; reset mid-sweep aborts and restarts
        bus.clear_req = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_req = 1'b0;
        @(negedge clk);
        check("clr_done_drop", 32'(bus.memrst_done), 0);
        check("clr_addr", 32'(bus.ram_addr), 0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(bus.ram_we), 0);
        check("midrst_addr", 32'(bus.ram_addr), 0);
        check("midrst_done", 32'(bus.memrst_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_done(1, 65, "midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gomoku_board_arbiter.md
GOMOKU_BOARD_ARBITER -- requirements
Module: gomoku_board_arbiter

Interface
REQ-001 The block SHALL have no parameters; the board is fixed at 8x8 cells, 6-bit cell address {x[2:0],y[2:0]}, 2-bit cell code (00 empty, 01 red, 10 green, 11 unused).
REQ-002 The ports SHALL be, one per line, name direction width meaning:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- clear_req  input  1  single-cycle pulse that requests a board clear (power-on or reset button)
- memrst_done  output  1  high when the board is cleared and clients are served
- wr_req / wr_addr / wr_data  input  1/6/2  move-write request, cell, code
- wr_ack  output  1  one-cycle pulse: write committed
- wr_reject  output  1  one-cycle pulse: write refused, cell occupied
- chk_req / chk_addr  input  1/6  win-checker read request, cell
- chk_ack  output  1  one-cycle pulse: read granted
- chk_valid / chk_rdata  output  1/2  read data valid the cycle after chk_ack
- scan_req / scan_addr  input  1/6  LED-scan read request, cell
- scan_ack  output  1  one-cycle pulse: read granted
- scan_valid / scan_rdata  output  1/2  read data valid the cycle after scan_ack
- ram_addr / ram_we / ram_wdata  output  6/1/2  single-port board RAM controls, combinational from the grant
- ram_rdata  input  2  RAM read data, valid one cycle after the address

Function
REQ-003 The block SHALL issue exactly one RAM access per cycle.
REQ-004 States SHALL be SWEEP, SERVE and, with the macro, WCHK; after reset the state SHALL be SWEEP with the sweep counter at 0.
REQ-005 In SWEEP, the block SHALL write 00 to address = counter each cycle, 0 to 63, with memrst_done low and no client acks.
REQ-006 After the write to address 63, the block SHALL enter SERVE and set memrst_done high on the next edge; a full sweep SHALL take exactly 64 cycles.
REQ-007 clear_req in any state SHALL force SWEEP with the counter at 0 on the next edge and drop memrst_done; clear_req during SWEEP SHALL restart the sweep; an in-flight write check SHALL be abandoned with no ack and no reject.
REQ-008 In SERVE, wr_req SHALL have top priority; chk_req and scan_req SHALL be round-robin arbitrated with a one-bit last-grant pointer (reset value favours chk), and the pointer SHALL update only when one of the two is granted.
REQ-009 Requesters SHALL hold req and address stable until ack or reject; the block SHALL never ack an absent request.
REQ-010 For a read grant in cycle N, the block SHALL pulse ack in N, drive ram_addr = client address in N, and assert valid with rdata = ram_rdata in N+1.
REQ-011 Without the macro, a write grant in cycle N SHALL drive ram_we=1, ram_addr=wr_addr and ram_wdata=wr_data in N and pulse wr_ack in N; wr_reject SHALL remain 0.
REQ-012 Reads and writes SHALL be issued back-to-back with no idle cycle; with no requests in SERVE, ram_we SHALL be 0.

Reset
REQ-013 While rst_n is low: all acks, valids, wr_reject, ram_we and memrst_done SHALL be 0; ram_addr, ram_wdata, chk_rdata and scan_rdata SHALL be 0; the state SHALL be SWEEP with the counter at 0 and the pointer favouring chk.
REQ-014 Reset assertion mid-sweep or mid-check SHALL abort immediately; the first edge after release SHALL begin the sweep at address 0.

Configuration
REQ-015 Macro GOMOKU_OCCUPY_CHECK_EN SHALL select the write behaviour.
- Defined: the write grant in cycle N SHALL read wr_addr (WCHK); in N+1, if ram_rdata==00, the block SHALL write and pulse wr_ack, otherwise it SHALL pulse wr_reject with ram_we=0. The RAM SHALL be owned by the writer in both cycles, and no read ack SHALL be issued in N or N+1.
- Undefined: the block SHALL follow REQ-011, and WCHK SHALL not exist.

Verification
REQ-016 Reset, then release -> memrst_done rises exactly 65 cycles after the release edge, and the RAM model shows all 64 cells = 00.
REQ-017 Sweep at counter 30 with clear_req pulsed -> counter restarts at 0; memrst_done rises 64 cycles after the pulse cycle.
REQ-018 chk_req and scan_req held continuously for 8 cycles -> acks alternate chk,scan,chk,...; each valid follows its ack by one cycle with the correct rdata.
REQ-019 wr_req(addr 0x3A, 01) together with chk_req -> wr_ack before chk_ack; a subsequent chk read of 0x3A returns 01.
REQ-020 With GOMOKU_OCCUPY_CHECK_EN: write 01 to 0x3A, then 10 to 0x3A -> first write gets wr_ack after 2 cycles, second gets wr_reject, and the cell stays 01. Without the macro: the second write is acked and the cell becomes 10.
